// File: rtl/meta_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : meta_scan_ctrl
// Description : Frame scan sequencer for the per-channel min/max metadata
//               accumulator. Clears the accumulator, streams NUM_PIXELS
//               pixels from the shared pixel memory through a grant-based
//               read port, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module meta_scan_ctrl #(
  parameter int ADDR_W     = 17,
  parameter int NUM_PIXELS = 76800,
  parameter int PIX_W      = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              stat_clr,
  output logic              stat_en,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   pix_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SCAN  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Index of the final read request of a frame.
  localparam logic [ADDR_W:0]   LAST_REQ = (ADDR_W+1)'(NUM_PIXELS - 1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  // The address register is loaded with base_addr on the accepted start and
  // advanced per grant, so it always equals base + request count (mod 2^ADDR_W).
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   req_cnt_q, req_cnt_d;
  logic [ADDR_W:0]   pix_cnt_q, pix_cnt_d;
  // Read-data valid: a grant was taken in the previous cycle.
  logic              vld_q, vld_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic              stat_clr_q, stat_clr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    req_cnt_d = req_cnt_q;
    pix_cnt_d = pix_cnt_q + (vld_q ? CNT_ONE : '0);
    vld_d     = mem_rd_en_q & mem_gnt;

    case (state_q)
      S_IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          state_d   = S_CLEAR;
          addr_d    = base_addr;
          req_cnt_d = '0;
          pix_cnt_d = '0;
        end
      end
      S_CLEAR: state_d = S_SCAN;
      S_SCAN: begin
        if (mem_gnt) begin
          req_cnt_d = req_cnt_q + CNT_ONE;
          addr_d    = addr_q + ADDR_ONE;
          if (req_cnt_q == LAST_REQ) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort discards any read still in flight so no stat_en follows it.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      vld_d   = 1'b0;
    end

    mem_rd_en_d = (state_d == S_SCAN);
    stat_clr_d  = (state_d == S_CLEAR);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  // State and output registers, all asynchronously reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      req_cnt_q   <= '0;
      pix_cnt_q   <= '0;
      vld_q       <= 1'b0;
      mem_rd_en_q <= 1'b0;
      stat_clr_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      req_cnt_q   <= req_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      vld_q       <= vld_d;
      mem_rd_en_q <= mem_rd_en_d;
      stat_clr_q  <= stat_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = addr_q;
  assign stat_clr  = stat_clr_q;
  assign stat_en   = vld_q;
  // Read data arrives the cycle after the grant, so it is forwarded straight
  // through while valid and forced to zero otherwise.
  assign pixel_out = vld_q ? mem_rdata : '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pix_cnt   = pix_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_meta_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_meta_scan_ctrl
// Description : Directed self-checking bench for meta_scan_ctrl. Three
//               instances (NUM_PIXELS = 4, 8, 1) share the stimulus; each has
//               its own pixel-memory model returning a per-test data table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_meta_scan_ctrl;

  localparam int AW = 17;
  localparam int PW = 12;
  localparam int ND = 3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          mem_gnt;
  logic          mem_clr;
  logic [AW-1:0] base_addr;

  logic          rd_en     [ND];
  logic [AW-1:0] mem_addr  [ND];
  logic          stat_clr  [ND];
  logic          stat_en   [ND];
  logic [PW-1:0] pixel_out [ND];
  logic          busy      [ND];
  logic          done      [ND];
  logic [AW:0]   pix_cnt   [ND];

  logic [PW-1:0] pat [8];

  int total;
  int bad;

  logic [AW-1:0] addrq[$];
  logic [PW-1:0] pixq[$];
  int clr_cnt, clr_cyc, first_en, done_cnt, done_cyc, end_cyc;
  int align_err, hold_err, both_err;
  bit finished;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int NP = (g == 0) ? 4 : ((g == 1) ? 8 : 1);
    logic [PW-1:0] rdata;
    int            gidx;

    meta_scan_ctrl #(.ADDR_W(AW), .NUM_PIXELS(NP), .PIX_W(PW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .base_addr (base_addr),
      .mem_rd_en (rd_en[g]),
      .mem_addr  (mem_addr[g]),
      .mem_gnt   (mem_gnt),
      .mem_rdata (rdata),
      .stat_clr  (stat_clr[g]),
      .stat_en   (stat_en[g]),
      .pixel_out (pixel_out[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .pix_cnt   (pix_cnt[g])
    );

    // memory model: k-th granted read returns pat[k] one cycle later
    always @(posedge clk) begin
      if (rd_en[g] && mem_gnt) rdata <= pat[gidx % 8];
      else                     rdata <= 12'hEEE;
      if (mem_clr)                  gidx <= 0;
      else if (rd_en[g] && mem_gnt) gidx <= gidx + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    start   = 1'b0;
    abort   = 1'b0;
    mem_gnt = 1'b1;
    repeat (30) tick();
    mem_gnt = 1'b0;
  endtask

  task automatic check_reset(input int s, input string p);
    check({p, "_rd_en"},  32'(rd_en[s]),     32'd0);
    check({p, "_addr"},   32'(mem_addr[s]),  32'd0);
    check({p, "_clr"},    32'(stat_clr[s]),  32'd0);
    check({p, "_en"},     32'(stat_en[s]),   32'd0);
    check({p, "_pix"},    32'(pixel_out[s]), 32'd0);
    check({p, "_busy"},   32'(busy[s]),      32'd0);
    check({p, "_done"},   32'(done[s]),      32'd0);
    check({p, "_cnt"},    32'(pix_cnt[s]),   32'd0);
  endtask

  task automatic check_addrs(input string tag, input logic [AW-1:0] b, input int n);
    logic [AW-1:0] e;
    check({tag, "_nreq"}, 32'(addrq.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      e = b + AW'(i);
      check({tag, "_addr"}, (i < addrq.size()) ? 32'(addrq[i]) : 32'hDEAD, 32'(e));
    end
  endtask

  task automatic check_pix(input string tag, input int n);
    check({tag, "_npix"}, 32'(pixq.size()), 32'(n));
    for (int i = 0; i < n; i++)
      check({tag, "_pix"}, (i < pixq.size()) ? 32'(pixq[i]) : 32'hDEAD, 32'(pat[i]));
  endtask

  // Start a scan and follow instance s cycle by cycle until it is idle again.
  // gmode 0: grant every cycle, 1: grant on odd cycles only.
  // abort_at >= 0: pulse abort once that many grants have been taken.
  // restart_cyc > 0: pulse start (with a new base) at that cycle and two later.
  task automatic run_scan(input int s, input logic [AW-1:0] base, input int gmode,
                          input int abort_at, input int restart_cyc);
    bit            g;
    bit            prev_g     = 1'b0;
    bit            prev_stall = 1'b0;
    bit            aborted    = 1'b0;
    int            gcount     = 0;
    logic [AW-1:0] prev_addr  = '0;
    addrq.delete();
    pixq.delete();
    clr_cnt = 0; clr_cyc = -1; first_en = -1; done_cnt = 0; done_cyc = -1;
    end_cyc = -1; align_err = 0; hold_err = 0; both_err = 0; finished = 1'b0;

    base_addr = base;
    start     = 1'b1;
    mem_clr   = 1'b1;
    mem_gnt   = 1'b0;
    tick();
    start   = 1'b0;
    mem_clr = 1'b0;

    for (int cyc = 1; cyc <= 60; cyc++) begin
      abort = 1'b0;
      start = 1'b0;
      g = (gmode == 0) ? 1'b1 : 1'((cyc % 2) == 1);
      if (abort_at >= 0 && !aborted && gcount == abort_at) begin
        abort   = 1'b1;
        aborted = 1'b1;
        g       = 1'b0;
      end
      if (restart_cyc > 0 && (cyc == restart_cyc || cyc == restart_cyc + 2)) begin
        start     = 1'b1;
        base_addr = 17'h01234;
      end
      mem_gnt = g;

      if (stat_clr[s]) begin
        clr_cnt++;
        if (clr_cyc < 0) clr_cyc = cyc;
        if (stat_en[s]) both_err++;
      end
      if (stat_en[s] != prev_g) align_err++;
      if (stat_en[s]) begin
        pixq.push_back(pixel_out[s]);
        if (first_en < 0) first_en = cyc;
      end
      if (rd_en[s] && prev_stall && mem_addr[s] != prev_addr) hold_err++;
      if (done[s]) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_g = rd_en[s] && g;
      if (rd_en[s] && g) begin
        addrq.push_back(mem_addr[s]);
        gcount++;
      end
      prev_stall = rd_en[s] && !g;
      prev_addr  = mem_addr[s];

      if (!busy[s]) begin
        finished = 1'b1;
        end_cyc  = cyc;
        break;
      end
      tick();
    end
    abort   = 1'b0;
    start   = 1'b0;
    mem_gnt = 1'b0;
    check("scan_finished", 32'(finished), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mem_gnt = 1'b0;
    mem_clr = 1'b0;
    base_addr = '0;
    for (int i = 0; i < 8; i++) pat[i] = 12'(12'h111 * (i + 1));

    // power-on reset values
    repeat (3) tick();
    check_reset(0, "por");
    rst_n = 1'b1;
    tick();

    // asynchronous reset in the middle of a scan
    base_addr = 17'h00100;
    mem_gnt   = 1'b1;
    mem_clr   = 1'b1;
    start     = 1'b1;
    tick();
    start   = 1'b0;
    mem_clr = 1'b0;
    tick();
    tick();
    check("rst_pre_rd_en", 32'(rd_en[0]),   32'd1);
    check("rst_pre_en",    32'(stat_en[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset(0, "async_rst");
    tick();
    rst_n = 1'b1;

    // full-grant scan, N=4, base 0x100
    settle();
    for (int i = 0; i < 8; i++) pat[i] = 12'(12'h123 + 12'h222 * i);
    run_scan(0, 17'h00100, 0, -1, -1);
    check("full_clr_cnt",  32'(clr_cnt),    32'd1);
    check("full_clr_cyc",  32'(clr_cyc),    32'd1);
    check_addrs("full", 17'h00100, 4);
    check_pix("full", 4);
    check("full_first_en", 32'(first_en),   32'd3);
    check("full_done_cyc", 32'(done_cyc),   32'd7);
    check("full_done_cnt", 32'(done_cnt),   32'd1);
    check("full_end_cyc",  32'(end_cyc),    32'd8);
    check("full_pix_cnt",  32'(pix_cnt[0]), 32'd4);
    check("full_align",    32'(align_err),  32'd0);
    check("full_clr_en",   32'(both_err),   32'd0);

    // grant stalls on alternate cycles, N=4
    settle();
    pat[0] = 12'h0F3; pat[1] = 12'hA10; pat[2] = 12'h5C7; pat[3] = 12'h001;
    run_scan(0, 17'h00020, 1, -1, -1);
    check_addrs("stall", 17'h00020, 4);
    check_pix("stall", 4);
    check("stall_hold",     32'(hold_err),   32'd0);
    check("stall_align",    32'(align_err),  32'd0);
    check("stall_first_en", 32'(first_en),   32'd4);
    check("stall_done_cyc", 32'(done_cyc),   32'd11);
    check("stall_pix_cnt",  32'(pix_cnt[0]), 32'd4);

    // address wrap at the top of the address space
    settle();
    run_scan(0, 17'h1FFFE, 0, -1, -1);
    check_addrs("wrap", 17'h1FFFE, 4);
    check("wrap_pix_cnt", 32'(pix_cnt[0]), 32'd4);

    // abort after two grants in an N=8 scan
    settle();
    for (int i = 0; i < 8; i++) pat[i] = 12'(12'h0A5 + 12'h101 * i);
    run_scan(1, 17'h00300, 0, 2, -1);
    check("abort_end_cyc",  32'(end_cyc),    32'd5);
    check("abort_done_cnt", 32'(done_cnt),   32'd0);
    check_pix("abort", 2);
    check("abort_pix_cnt",  32'(pix_cnt[1]), 32'd2);
    check("abort_align",    32'(align_err),  32'd0);
    mem_gnt = 1'b1;
    repeat (3) begin
      tick();
      check("post_abort_en",   32'(stat_en[1]), 32'd0);
      check("post_abort_busy", 32'(busy[1]),    32'd0);
    end
    mem_gnt = 1'b0;

    // clean N=8 scan after the abort
    settle();
    run_scan(1, 17'h00300, 0, -1, -1);
    check("clean_clr_cnt",  32'(clr_cnt),    32'd1);
    check_addrs("clean", 17'h00300, 8);
    check_pix("clean", 8);
    check("clean_done_cyc", 32'(done_cyc),   32'd11);
    check("clean_pix_cnt",  32'(pix_cnt[1]), 32'd8);

    // start pulses while busy are ignored
    settle();
    run_scan(0, 17'h00040, 0, -1, 3);
    check_addrs("busy_start", 17'h00040, 4);
    check("busy_start_clr",  32'(clr_cnt),    32'd1);
    check("busy_start_done", 32'(done_cyc),   32'd7);
    check("busy_start_cnt",  32'(pix_cnt[0]), 32'd4);

    // single-pixel frame
    settle();
    run_scan(2, 17'h000AA, 0, -1, -1);
    check_addrs("one", 17'h000AA, 1);
    check_pix("one", 1);
    check("one_first_en", 32'(first_en),   32'd3);
    check("one_done_cyc", 32'(done_cyc),   32'd4);
    check("one_end_cyc",  32'(end_cyc),    32'd5);
    check("one_pix_cnt",  32'(pix_cnt[2]), 32'd1);

    // start and abort together in IDLE
    settle();
    base_addr = 17'h00155;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy",  32'(busy[0]),     32'd0);
    check("sa_clr",   32'(stat_clr[0]), 32'd0);
    tick();
    check("sa_busy2", 32'(busy[0]),     32'd0);
    check("sa_rd_en", 32'(rd_en[0]),    32'd0);
    check("sa_cnt",   32'(pix_cnt[0]),  32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
